pkt_dsc_dispatcher: RTL and testbench

Sits directly downstream of the packet queue manager and forks its annotated metadata stream into two streams. The first is a packet-write stream to the PCIe data writer, which carries every packet. The second is a descriptor-request stream, which carries one request for each packet flagged `needs_dsc`. The block computes the post-write tail pointer for each descriptor, buffers descriptor requests in a small FIFO, and keeps statistics counters.

---
 rtl/pkt_dsc_dispatcher_pkg.sv | 33 +++
 rtl/pkt_dsc_dispatcher_dsc_req_fifo.sv | 72 +++++++
 rtl/pkt_dsc_dispatcher.sv | 141 ++++++++++++++
 tb/tb_pkt_dsc_dispatcher.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_dsc_dispatcher_pkg.sv
// Shared PCIe constants and metadata types used by the packet/descriptor
// dispatch path.
package pkt_dsc_dispatcher_pkg;

   localparam int QUEUE_ID_W      = 12;
   localparam int PTR_W           = 26;
   localparam int PKT_SIZE_W      = 16;
   localparam int FLIT_BYTES      = 64;
   localparam int FLIT_BYTES_LOG2 = 6;

   // Ring-buffer pointer pair of a packet queue, in flits.
   typedef struct packed {
      logic [PTR_W-1:0] head;
      logic [PTR_W-1:0] tail;
   } pkt_q_state_t;

   // Packet metadata annotated by the queue manager.
   typedef struct packed {
      logic [QUEUE_ID_W-1:0] pkt_queue_id;
      logic [QUEUE_ID_W-1:0] dsc_queue_id;
      pkt_q_state_t          pkt_q_state;
      logic [PKT_SIZE_W-1:0] size;
      logic                  needs_dsc;
   } pkt_meta_with_queues_t;

   // Descriptor request: which queues, and where the packet tail ends up.
   typedef struct packed {
      logic [QUEUE_ID_W-1:0] pkt_queue_id;
      logic [QUEUE_ID_W-1:0] dsc_queue_id;
      logic [PTR_W-1:0]      new_tail;
   } dsc_req_t;

endpackage

// File: rtl/pkt_dsc_dispatcher_dsc_req_fifo.sv
// First-word-fall-through FIFO with synchronous reset and occupancy output.
// Full-state admission is computed from the registered occupancy only, so
// push_ready never depends on pop_ready.
module dsc_req_fifo
   import pkt_dsc_dispatcher_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int DATA_W = $bits(dsc_req_t)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_valid,
   input  logic [DATA_W-1:0]        push_data,
   output logic                     push_ready,
   output logic                     pop_valid,
   output logic [DATA_W-1:0]        pop_data,
   input  logic                     pop_ready,
   output logic [$clog2(DEPTH):0]   occup
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] OCC_ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   occup_q, occup_d;
   logic              do_push;
   logic              do_pop;

   assign push_ready = (occup_q != DEPTH_C);
   assign pop_valid  = (occup_q != '0);
   assign pop_data   = mem_q[rd_ptr_q];
   assign occup      = occup_q;
   assign do_push    = push_valid && push_ready;
   assign do_pop     = pop_valid && pop_ready;

   // Next-state pointers and occupancy from this cycle's push/pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occup_d  = occup_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
         2'b10:   occup_d = occup_q + OCC_ONE;
         2'b01:   occup_d = occup_q - OCC_ONE;
         default: occup_d = occup_q;
      endcase
   end

   // Control state; reset empties the FIFO in one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occup_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occup_q  <= occup_d;
      end
   end

   // Storage; contents are meaningless while the slot is unoccupied.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/pkt_dsc_dispatcher.sv
// Forks the queue-manager metadata stream into a packet-write stream (every
// packet) and a descriptor-request stream (packets flagged needs_dsc), with
// the post-write tail pointer computed here. Both streams advance together:
// a packet is only taken when its descriptor (if any) also has room.
module pkt_dsc_dispatcher
   import pkt_dsc_dispatcher_pkg::*;
#(
   parameter int DSC_FIFO_DEPTH = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  pkt_meta_with_queues_t             in_meta_data,
   input  logic                              in_meta_valid,
   output logic                              in_meta_ready,
   output pkt_meta_with_queues_t             out_pkt_meta_data,
   output logic                              out_pkt_meta_valid,
   input  logic                              out_pkt_meta_ready,
   output dsc_req_t                          out_dsc_req_data,
   output logic                              out_dsc_req_valid,
   input  logic                              out_dsc_req_ready,
   input  logic [PTR_W-1:0]                  rb_size,
   output logic [$clog2(DSC_FIFO_DEPTH):0]   dsc_fifo_occup,
   output logic [31:0]                       pkt_cnt,
   output logic [31:0]                       dsc_cnt,
   output logic [31:0]                       dsc_stall_cnt
);

   // Flit count of a packet, rounding any partial 64 B flit up.
   function automatic logic [PTR_W:0] flits_of(input logic [PKT_SIZE_W-1:0] size);
      logic [PKT_SIZE_W:0] rounded;
      rounded = {1'b0, size} + (PKT_SIZE_W+1)'(FLIT_BYTES - 1);
      return (PTR_W+1)'(rounded >> FLIT_BYTES_LOG2);
   endfunction

   // Single-subtraction wrap of a tail sum into a ring of rb flits; the ring
   // size need not be a power of two.
   function automatic logic [PTR_W-1:0] wrap_tail(input logic [PTR_W:0]   sum,
                                                  input logic [PTR_W-1:0] rb);
      logic [PTR_W:0] rb_ext;
      logic [PTR_W:0] diff;
      rb_ext = {1'b0, rb};
      diff   = sum - rb_ext;
      return (sum >= rb_ext) ? diff[PTR_W-1:0] : sum[PTR_W-1:0];
   endfunction

   pkt_meta_with_queues_t out_pkt_data_q, out_pkt_data_d;
   logic                  out_pkt_vld_q, out_pkt_vld_d;
   logic [31:0]           pkt_cnt_q, pkt_cnt_d;
   logic [31:0]           dsc_cnt_q, dsc_cnt_d;
   logic [31:0]           dsc_stall_cnt_q, dsc_stall_cnt_d;

   dsc_req_t              dsc_req_in;
   logic [PTR_W:0]        tail_sum;
   logic                  pkt_stage_free;
   logic                  fifo_has_room;
   logic                  accept;
   logic                  dsc_push;
   logic                  dsc_pop;

   // Packet register can take a new packet if empty or draining this cycle.
   assign pkt_stage_free = !out_pkt_vld_q || out_pkt_meta_ready;
   assign in_meta_ready  = !rst && pkt_stage_free &&
                           (!in_meta_data.needs_dsc || fifo_has_room);
   assign accept         = in_meta_valid && in_meta_ready;
   assign dsc_push       = accept && in_meta_data.needs_dsc;
   assign dsc_pop        = out_dsc_req_valid && out_dsc_req_ready;

   // Descriptor request built from the incoming packet and the ring size.
   always_comb begin
      tail_sum                = {1'b0, in_meta_data.pkt_q_state.tail} +
                                flits_of(in_meta_data.size);
      dsc_req_in.pkt_queue_id = in_meta_data.pkt_queue_id;
      dsc_req_in.dsc_queue_id = in_meta_data.dsc_queue_id;
      dsc_req_in.new_tail     = wrap_tail(tail_sum, rb_size);
   end

   dsc_req_fifo #(
      .DEPTH  (DSC_FIFO_DEPTH),
      .DATA_W ($bits(dsc_req_t))
   ) u_dsc_req_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_valid (dsc_push),
      .push_data  (dsc_req_in),
      .push_ready (fifo_has_room),
      .pop_valid  (out_dsc_req_valid),
      .pop_data   (out_dsc_req_data),
      .pop_ready  (out_dsc_req_ready),
      .occup      (dsc_fifo_occup)
   );

   // Packet output register: load on accept, hold until the consumer takes it.
   always_comb begin
      out_pkt_vld_d  = out_pkt_vld_q;
      out_pkt_data_d = out_pkt_data_q;
      if (accept) begin
         out_pkt_vld_d  = 1'b1;
         out_pkt_data_d = in_meta_data;
      end else if (out_pkt_meta_ready) begin
         out_pkt_vld_d  = 1'b0;
      end
   end

   // Statistics counters, free-running modulo 2^32.
   always_comb begin
      pkt_cnt_d       = pkt_cnt_q;
      dsc_cnt_d       = dsc_cnt_q;
      dsc_stall_cnt_d = dsc_stall_cnt_q;
      if (accept)  pkt_cnt_d = pkt_cnt_q + 32'd1;
      if (dsc_pop) dsc_cnt_d = dsc_cnt_q + 32'd1;
      if (in_meta_valid && in_meta_data.needs_dsc && !fifo_has_room)
         dsc_stall_cnt_d = dsc_stall_cnt_q + 32'd1;
   end

   // Control state: output valid and counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_pkt_vld_q   <= 1'b0;
         pkt_cnt_q       <= '0;
         dsc_cnt_q       <= '0;
         dsc_stall_cnt_q <= '0;
      end else begin
         out_pkt_vld_q   <= out_pkt_vld_d;
         pkt_cnt_q       <= pkt_cnt_d;
         dsc_cnt_q       <= dsc_cnt_d;
         dsc_stall_cnt_q <= dsc_stall_cnt_d;
      end
   end

   // Packet payload register; qualified by out_pkt_vld_q, so not reset.
   always_ff @(posedge clk) begin
      out_pkt_data_q <= out_pkt_data_d;
   end

   assign out_pkt_meta_valid = out_pkt_vld_q;
   assign out_pkt_meta_data  = out_pkt_data_q;
   assign pkt_cnt            = pkt_cnt_q;
   assign dsc_cnt            = dsc_cnt_q;
   assign dsc_stall_cnt      = dsc_stall_cnt_q;

endmodule

// File: tb/tb_pkt_dsc_dispatcher.sv
// Self-checking bench for pkt_dsc_dispatcher: scoreboard queues for both
// output streams plus per-scenario directed checks.
module tb_pkt_dsc_dispatcher;
   import pkt_dsc_dispatcher_pkg::*;

   localparam int DEPTH = 16;
   localparam int OCC_W = $clog2(DEPTH) + 1;

   logic                  clk = 1'b0;
   logic                  rst;
   pkt_meta_with_queues_t in_meta_data;
   logic                  in_meta_valid;
   logic                  in_meta_ready;
   pkt_meta_with_queues_t out_pkt_meta_data;
   logic                  out_pkt_meta_valid;
   logic                  out_pkt_meta_ready;
   dsc_req_t              out_dsc_req_data;
   logic                  out_dsc_req_valid;
   logic                  out_dsc_req_ready;
   logic [PTR_W-1:0]      rb_size;
   logic [OCC_W-1:0]      dsc_fifo_occup;
   logic [31:0]           pkt_cnt, dsc_cnt, dsc_stall_cnt;

   always #5 clk = ~clk;

   pkt_dsc_dispatcher #(.DSC_FIFO_DEPTH(DEPTH)) dut (
      .clk                (clk),
      .rst                (rst),
      .in_meta_data       (in_meta_data),
      .in_meta_valid      (in_meta_valid),
      .in_meta_ready      (in_meta_ready),
      .out_pkt_meta_data  (out_pkt_meta_data),
      .out_pkt_meta_valid (out_pkt_meta_valid),
      .out_pkt_meta_ready (out_pkt_meta_ready),
      .out_dsc_req_data   (out_dsc_req_data),
      .out_dsc_req_valid  (out_dsc_req_valid),
      .out_dsc_req_ready  (out_dsc_req_ready),
      .rb_size            (rb_size),
      .dsc_fifo_occup     (dsc_fifo_occup),
      .pkt_cnt            (pkt_cnt),
      .dsc_cnt            (dsc_cnt),
      .dsc_stall_cnt      (dsc_stall_cnt)
   );

   int tests_run    = 0;
   int tests_failed = 0;
   pkt_meta_with_queues_t pkt_exp_q[$];
   dsc_req_t              dsc_exp_q[$];
   int pkt_pops = 0;
   int dsc_pops = 0;
   int acc_cnt  = 0;
   int wait_cnt = 0;
   bit rand_ready = 1'b0;

   function automatic pkt_meta_with_queues_t make_meta(input int pq, input int dq,
         input int tail, input int size, input bit nd);
      pkt_meta_with_queues_t m;
      m.pkt_queue_id     = QUEUE_ID_W'(pq);
      m.dsc_queue_id     = QUEUE_ID_W'(dq);
      m.pkt_q_state.head = PTR_W'(tail ^ 32'h155);
      m.pkt_q_state.tail = PTR_W'(tail);
      m.size             = PKT_SIZE_W'(size);
      m.needs_dsc        = nd;
      return m;
   endfunction

   // Reference: ceil(size/64) flits added to tail, wrapped once by rb.
   function automatic dsc_req_t model_dsc(input pkt_meta_with_queues_t m,
                                          input logic [PTR_W-1:0] rb);
      longint flits, sum, nt;
      dsc_req_t r;
      flits = (longint'(m.size) + 63) / 64;
      sum   = longint'(m.pkt_q_state.tail) + flits;
      nt    = (sum >= longint'(rb)) ? sum - longint'(rb) : sum;
      r.pkt_queue_id = m.pkt_queue_id;
      r.dsc_queue_id = m.dsc_queue_id;
      r.new_tail     = nt[PTR_W-1:0];
      return r;
   endfunction

   // Present one packet from posedge+1 and return at the negedge where it is
   // known to be accepted on the following posedge.
   task automatic send(input pkt_meta_with_queues_t m, input logic [PTR_W-1:0] rb,
                       input int budget);
      bit acc = 1'b0;
      @(posedge clk); #1;
      in_meta_data  = m;
      in_meta_valid = 1'b1;
      rb_size       = rb;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (in_meta_ready) begin acc = 1'b1; break; end
         wait_cnt++;
      end
      tests_run++;
      if (acc) begin
         pkt_exp_q.push_back(m);
         if (m.needs_dsc) dsc_exp_q.push_back(model_dsc(m, rb));
         acc_cnt++;
      end else begin
         tests_failed++;
         in_meta_valid = 1'b0;
         $display("FAIL send_timeout: accepted=0 required=1 within %0d cycles", budget);
      end
   endtask

   task automatic idle();
      @(posedge clk); #1;
      in_meta_valid = 1'b0;
   endtask

   // Output monitor: scoreboard pops and hold-stability of the packet stream.
   initial begin
      pkt_meta_with_queues_t prev_data, exp_p;
      dsc_req_t exp_d;
      bit prev_stall;
      prev_stall = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               tests_run++;
               if (out_pkt_meta_valid !== 1'b1 || out_pkt_meta_data !== prev_data) begin
                  tests_failed++;
                  $display("FAIL pkt_hold: valid=%0b data=%h required valid=1 data=%h",
                           out_pkt_meta_valid, out_pkt_meta_data, prev_data);
               end
            end
            prev_stall = out_pkt_meta_valid && !out_pkt_meta_ready;
            prev_data  = out_pkt_meta_data;
            if (out_pkt_meta_valid && out_pkt_meta_ready) begin
               pkt_pops++;
               tests_run++;
               if (pkt_exp_q.size() == 0) begin
                  tests_failed++;
                  $display("FAIL pkt_unexpected: got %h required no output", out_pkt_meta_data);
               end else begin
                  exp_p = pkt_exp_q.pop_front();
                  if (out_pkt_meta_data !== exp_p) begin
                     tests_failed++;
                     $display("FAIL pkt_data: got %h required %h", out_pkt_meta_data, exp_p);
                  end
               end
            end
            if (out_dsc_req_valid && out_dsc_req_ready) begin
               dsc_pops++;
               tests_run++;
               if (dsc_exp_q.size() == 0) begin
                  tests_failed++;
                  $display("FAIL dsc_unexpected: got %h required no output", out_dsc_req_data);
               end else begin
                  exp_d = dsc_exp_q.pop_front();
                  if (out_dsc_req_data !== exp_d) begin
                     tests_failed++;
                     $display("FAIL dsc_data: got %h required %h", out_dsc_req_data, exp_d);
                  end
               end
            end
         end
      end
   end

   // Random backpressure on both output streams when enabled.
   initial begin
      forever begin
         @(posedge clk); #1;
         if (rand_ready) begin
            out_pkt_meta_ready = 1'($urandom_range(0, 1));
            out_dsc_req_ready  = 1'($urandom_range(0, 1));
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1;
      in_meta_data  = make_meta(1, 1, 0, 64, 1'b0);
      in_meta_valid = 1'b1;
      @(negedge clk);
      tests_run++;
      if (in_meta_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_ready: got %0b required 0", in_meta_ready); end
      @(posedge clk); #1;
      rst = 1'b0;
      in_meta_valid = 1'b0;
      @(negedge clk);
      tests_run++; if (out_pkt_meta_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_pkt_valid: got %0b required 0", out_pkt_meta_valid); end
      tests_run++; if (out_dsc_req_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_dsc_valid: got %0b required 0", out_dsc_req_valid); end
      tests_run++; if (dsc_fifo_occup !== '0) begin tests_failed++; $display("FAIL rst_occup: got %0d required 0", dsc_fifo_occup); end
      tests_run++; if (pkt_cnt !== 32'd0 || dsc_cnt !== 32'd0 || dsc_stall_cnt !== 32'd0) begin
         tests_failed++; $display("FAIL rst_counters: got %0d/%0d/%0d required 0/0/0", pkt_cnt, dsc_cnt, dsc_stall_cnt); end
   endtask

   task automatic test_single();
      out_pkt_meta_ready = 1'b1;
      out_dsc_req_ready  = 1'b0;
      send(make_meta(3, 7, 10, 64, 1'b1), 26'd1024, 20);
      idle();
      @(negedge clk);
      tests_run++; if (out_pkt_meta_valid !== 1'b1) begin tests_failed++; $display("FAIL single_pkt_latency: valid=%0b required 1", out_pkt_meta_valid); end
      tests_run++; if (out_dsc_req_valid !== 1'b1) begin tests_failed++; $display("FAIL single_dsc_latency: valid=%0b required 1", out_dsc_req_valid); end
      tests_run++; if (out_dsc_req_data.new_tail !== 26'd11) begin tests_failed++; $display("FAIL single_new_tail: got %0d required 11", out_dsc_req_data.new_tail); end
      tests_run++; if (pkt_cnt !== 32'd1) begin tests_failed++; $display("FAIL single_pkt_cnt: got %0d required 1", pkt_cnt); end
      tests_run++; if (dsc_cnt !== 32'd0) begin tests_failed++; $display("FAIL single_dsc_cnt_pre: got %0d required 0", dsc_cnt); end
      @(posedge clk); #1; out_dsc_req_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1; out_dsc_req_ready = 1'b0;
      @(negedge clk);
      tests_run++; if (dsc_cnt !== 32'd1) begin tests_failed++; $display("FAIL single_dsc_cnt: got %0d required 1", dsc_cnt); end
      tests_run++; if (dsc_fifo_occup !== '0) begin tests_failed++; $display("FAIL single_occup: got %0d required 0", dsc_fifo_occup); end
   endtask

   task automatic test_wrap();
      out_pkt_meta_ready = 1'b1;
      out_dsc_req_ready  = 1'b0;
      send(make_meta(5, 6, 1020, 300, 1'b1), 26'd1024, 20);
      send(make_meta(8, 9, 998, 128, 1'b1), 26'd1000, 20);
      idle();
      @(negedge clk);
      tests_run++; if (dsc_fifo_occup !== OCC_W'(2)) begin tests_failed++; $display("FAIL wrap_occup: got %0d required 2", dsc_fifo_occup); end
      tests_run++; if (out_dsc_req_data.new_tail !== 26'd1) begin tests_failed++; $display("FAIL wrap_pow2_tail: got %0d required 1", out_dsc_req_data.new_tail); end
      @(posedge clk); #1; out_dsc_req_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      tests_run++; if (out_dsc_req_data.new_tail !== 26'd0) begin tests_failed++; $display("FAIL wrap_npow2_tail: got %0d required 0", out_dsc_req_data.new_tail); end
      @(posedge clk); #1; out_dsc_req_ready = 1'b0;
      @(negedge clk);
      tests_run++; if (dsc_fifo_occup !== '0) begin tests_failed++; $display("FAIL wrap_drain: got %0d required 0", dsc_fifo_occup); end
   endtask

   task automatic test_no_dsc_stream();
      int w0, p0, d0, pc0;
      out_pkt_meta_ready = 1'b1;
      out_dsc_req_ready  = 1'b1;
      w0 = wait_cnt; p0 = pkt_pops; d0 = dsc_pops; pc0 = int'(pkt_cnt);
      for (int i = 0; i < 100; i++)
         send(make_meta(i, 100 - i, int'($urandom_range(0, 1000)),
                        int'($urandom_range(1, 2000)), 1'b0), 26'd1024, 5);
      idle();
      @(negedge clk);
      @(negedge clk);
      tests_run++; if (wait_cnt - w0 !== 0) begin tests_failed++; $display("FAIL nodsc_ready_low: got %0d low cycles required 0", wait_cnt - w0); end
      tests_run++; if (pkt_pops - p0 !== 100) begin tests_failed++; $display("FAIL nodsc_pkt_out: got %0d required 100", pkt_pops - p0); end
      tests_run++; if (int'(pkt_cnt) - pc0 !== 100) begin tests_failed++; $display("FAIL nodsc_pkt_cnt: got %0d required 100", int'(pkt_cnt) - pc0); end
      tests_run++; if (dsc_pops - d0 !== 0 || dsc_fifo_occup !== '0) begin
         tests_failed++; $display("FAIL nodsc_dsc_out: got %0d pops occup %0d required 0/0", dsc_pops - d0, dsc_fifo_occup); end
   endtask

   task automatic test_dsc_backpressure();
      int a0, w0, s0, dp0, dc0;
      out_pkt_meta_ready = 1'b1;
      out_dsc_req_ready  = 1'b0;
      a0 = acc_cnt; w0 = wait_cnt; s0 = int'(dsc_stall_cnt); dp0 = dsc_pops; dc0 = int'(dsc_cnt);
      fork
         begin
            for (int i = 0; i < 20; i++)
               send(make_meta(100 + i, 200 + i, 50 * i, 64 * (i + 1), 1'b1), 26'd1024, 100);
            idle();
         end
         begin
            bit seen = 1'b0;
            for (int k = 0; k < 100; k++) begin
               @(negedge clk);
               if (acc_cnt - a0 >= 16) begin seen = 1'b1; break; end
            end
            tests_run++; if (!seen) begin tests_failed++; $display("FAIL bp_fill_timeout: accepted %0d required 16", acc_cnt - a0); end
            for (int k = 0; k < 6; k++) begin
               @(negedge clk);
               tests_run++; if (in_meta_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_ready_full: got %0b required 0", in_meta_ready); end
            end
            tests_run++; if (acc_cnt - a0 !== 16) begin tests_failed++; $display("FAIL bp_accepted: got %0d required 16", acc_cnt - a0); end
            tests_run++; if (dsc_fifo_occup !== OCC_W'(DEPTH)) begin tests_failed++; $display("FAIL bp_occup_full: got %0d required %0d", dsc_fifo_occup, DEPTH); end
            @(posedge clk); #1; out_dsc_req_ready = 1'b1;
         end
      join
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (dsc_fifo_occup == '0) break;
      end
      @(negedge clk);
      tests_run++; if (int'(dsc_stall_cnt) - s0 !== wait_cnt - w0 || wait_cnt - w0 < 6) begin
         tests_failed++; $display("FAIL bp_stall_cnt: got %0d required %0d (>=6)", int'(dsc_stall_cnt) - s0, wait_cnt - w0); end
      tests_run++; if (dsc_pops - dp0 !== 20) begin tests_failed++; $display("FAIL bp_drain: got %0d required 20", dsc_pops - dp0); end
      tests_run++; if (int'(dsc_cnt) - dc0 !== 20) begin tests_failed++; $display("FAIL bp_dsc_cnt: got %0d required 20", int'(dsc_cnt) - dc0); end
      tests_run++; if (dsc_exp_q.size() !== 0) begin tests_failed++; $display("FAIL bp_leftover: got %0d pending required 0", dsc_exp_q.size()); end
   endtask

   task automatic test_random_backpressure();
      int a0, pc0;
      a0 = acc_cnt; pc0 = int'(pkt_cnt);
      @(posedge clk); #1; rand_ready = 1'b1;
      for (int i = 0; i < 40; i++)
         send(make_meta(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
                        int'($urandom_range(0, 1023)), int'($urandom_range(1, 4096)),
                        1'($urandom_range(0, 1))), 26'd1024, 200);
      idle();
      rand_ready = 1'b0;
      out_pkt_meta_ready = 1'b1;
      out_dsc_req_ready  = 1'b1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (pkt_exp_q.size() == 0 && dsc_exp_q.size() == 0) break;
      end
      @(negedge clk);
      tests_run++; if (pkt_exp_q.size() !== 0 || dsc_exp_q.size() !== 0) begin
         tests_failed++; $display("FAIL rand_lost: got %0d/%0d pending required 0/0", pkt_exp_q.size(), dsc_exp_q.size()); end
      tests_run++; if (int'(pkt_cnt) - pc0 !== acc_cnt - a0 || acc_cnt - a0 !== 40) begin
         tests_failed++; $display("FAIL rand_pkt_cnt: got %0d required 40", int'(pkt_cnt) - pc0); end
   endtask

   task automatic test_reset_mid();
      out_pkt_meta_ready = 1'b1;
      out_dsc_req_ready  = 1'b0;
      for (int i = 0; i < 5; i++)
         send(make_meta(i, i + 1, i * 3, 128, 1'b1), 26'd1024, 20);
      @(posedge clk); #1;
      out_pkt_meta_ready = 1'b0;
      in_meta_valid      = 1'b0;
      @(negedge clk);
      tests_run++; if (dsc_fifo_occup !== OCC_W'(5)) begin tests_failed++; $display("FAIL rmid_pre_occup: got %0d required 5", dsc_fifo_occup); end
      tests_run++; if (out_pkt_meta_valid !== 1'b1) begin tests_failed++; $display("FAIL rmid_pre_valid: got %0b required 1", out_pkt_meta_valid); end
      @(posedge clk); #1;
      rst = 1'b1;
      in_meta_valid = 1'b1;
      @(negedge clk);
      tests_run++; if (in_meta_ready !== 1'b0) begin tests_failed++; $display("FAIL rmid_ready: got %0b required 0", in_meta_ready); end
      @(posedge clk); #1;
      rst = 1'b0;
      in_meta_valid      = 1'b0;
      out_pkt_meta_ready = 1'b1;
      out_dsc_req_ready  = 1'b1;
      pkt_exp_q.delete();
      dsc_exp_q.delete();
      @(negedge clk);
      tests_run++; if (out_pkt_meta_valid !== 1'b0 || out_dsc_req_valid !== 1'b0) begin
         tests_failed++; $display("FAIL rmid_valids: got %0b/%0b required 0/0", out_pkt_meta_valid, out_dsc_req_valid); end
      tests_run++; if (dsc_fifo_occup !== '0) begin tests_failed++; $display("FAIL rmid_occup: got %0d required 0", dsc_fifo_occup); end
      tests_run++; if (pkt_cnt !== 32'd0 || dsc_cnt !== 32'd0 || dsc_stall_cnt !== 32'd0) begin
         tests_failed++; $display("FAIL rmid_counters: got %0d/%0d/%0d required 0/0/0", pkt_cnt, dsc_cnt, dsc_stall_cnt); end
      @(negedge clk);
      tests_run++; if (out_pkt_meta_valid !== 1'b0 || out_dsc_req_valid !== 1'b0) begin
         tests_failed++; $display("FAIL rmid_quiet: got %0b/%0b required 0/0", out_pkt_meta_valid, out_dsc_req_valid); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
      $fatal(1, "watchdog");
   end

   initial begin
      rst                = 1'b1;
      in_meta_valid      = 1'b0;
      in_meta_data       = '0;
      out_pkt_meta_ready = 1'b1;
      out_dsc_req_ready  = 1'b1;
      rb_size            = 26'd1024;
      test_reset();
      test_single();
      test_wrap();
      test_no_dsc_stream();
      test_dsc_backpressure();
      test_random_backpressure();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
